// File: rtl/env_mult.sv
// Serial MSB-first shift-add multiplier scaling a signed voice sample by an unsigned envelope level.
// Fixed ENV_W+2 cycle turnaround; requests while busy are dropped, not queued.
module env_mult #(
  parameter int WAVE_W = 12,
  parameter int ENV_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WAVE_W-1:0] wave_i,
  input  logic [ENV_W-1:0]  env_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [WAVE_W-1:0] product_o
);

  localparam int AW = WAVE_W + ENV_W;
  localparam int CW = $clog2(ENV_W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WAVE_W-1:0] wave_q, wave_d;
  logic [ENV_W-1:0]  env_q, env_d;
  logic [WAVE_W-1:0] product_q, product_d;

  logic [AW-1:0]     addend;
  logic [AW-1:0]     acc_next;
  logic              last_iter;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wave_d    = wave_q;
    env_d     = env_q;
    product_d = product_q;

    // env_q is shifted left each iteration so its MSB is always the bit in play
    addend    = env_q[ENV_W-1] ? {{ENV_W{wave_q[WAVE_W-1]}}, wave_q} : '0;
    acc_next  = {acc_q[AW-2:0], 1'b0} + addend;
    last_iter = (cnt_q == CW'(ENV_W - 1));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          wave_d  = wave_i;
          env_d   = env_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = acc_next;
        env_d = {env_q[ENV_W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          product_d = acc_next[AW-1:ENV_W];
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      wave_q    <= '0;
      env_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wave_q    <= wave_d;
      env_q     <= env_d;
      product_q <= product_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign ready_o   = (state_q == S_DONE);
  assign product_o = product_q;

endmodule

// File: tb/tb_env_mult.sv
// Randomized and directed bench for env_mult against a floor(wave*env/256) reference.
module tb_env_mult;

  localparam int WAVE_W = 12;
  localparam int ENV_W  = 8;

  logic              clk_i;
  logic              rst_i;
  logic              start_i;
  logic [WAVE_W-1:0] wave_i;
  logic [ENV_W-1:0]  env_i;
  logic              busy_o;
  logic              ready_o;
  logic [WAVE_W-1:0] product_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last = 0;

  env_mult #(.WAVE_W(WAVE_W), .ENV_W(ENV_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .wave_i    (wave_i),
    .env_i     (env_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .product_o (product_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor division of the exact product by 2^ENV_W
  function automatic int ref_mult(input int w, input int e);
    int p;
    int q;
    p = w * e;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int prod_int();
    return int'($signed(product_o));
  endfunction

  task automatic drive_ops(input int w, input int e);
    int wv;
    int ev;
    wv = w;
    ev = e;
    wave_i = wv[WAVE_W-1:0];
    env_i  = ev[ENV_W-1:0];
  endtask

  task automatic scramble();
    int unsigned r;
    r = $urandom;
    wave_i = r[WAVE_W-1:0];
    env_i  = r[WAVE_W+ENV_W-1:WAVE_W];
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) check("idle_timeout", 1, 0);
  endtask

  // One operation; with disturb set, extra starts land in a BUSY cycle and the DONE cycle
  task automatic do_op(input int w, input int e, input bit disturb);
    int exp_p;
    int rdy_cnt;
    exp_p   = ref_mult(w, e);
    rdy_cnt = 0;
    wait_idle();
    @(negedge clk_i);
    start_i = 1'b1;
    drive_ops(w, e);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk_i);
      check($sformatf("busy w=%0d e=%0d k=%0d", w, e, k), int'(busy_o), (k <= 9) ? 1 : 0);
      check($sformatf("ready w=%0d e=%0d k=%0d", w, e, k), int'(ready_o), (k == 9) ? 1 : 0);
      if (ready_o) rdy_cnt++;
      if (k == 9 || k == 11) check($sformatf("product w=%0d e=%0d k=%0d", w, e, k), prod_int(), exp_p);
      start_i = 1'b0;
      if (k == 1) scramble();
      if (disturb && (k == 3 || k == 9)) begin
        start_i = 1'b1;
        scramble();
      end
    end
    start_i = 1'b0;
    check($sformatf("ready_count w=%0d e=%0d", w, e), rdy_cnt, 1);
    exp_last = exp_p;
  endtask

  int dir_w [8] = '{1000, 2047, -2048, -2048, -1, 1, -300, 0};
  int dir_e [8] = '{128,  255,   255,     0,  1, 1,    3, 77};

  initial begin
    int rdy_seen;
    int busy_seen;
    rst_i   = 1'b1;
    start_i = 1'b0;
    wave_i  = '0;
    env_i   = '0;
    #1;
    check("reset_product", prod_int(), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_ready", int'(ready_o), 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) do_op(dir_w[i], dir_e[i], 1'b0);
    do_op(-777, 200, 1'b1);
    do_op(1500, 99, 1'b1);

    // Abort in the middle of an operation
    @(negedge clk_i);
    start_i = 1'b1;
    drive_ops(500, 77);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    rst_i = 1'b1;
    #1;
    check("midrst_product", prod_int(), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_ready", int'(ready_o), 0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    rdy_seen  = 0;
    busy_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (ready_o) rdy_seen++;
      if (busy_o) busy_seen++;
    end
    check("midrst_no_ready", rdy_seen, 0);
    check("midrst_no_busy", busy_seen, 0);
    exp_last = 0;
    do_op(321, 200, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int w;
      int e;
      w = int'($urandom_range(0, 4095)) - 2048;
      e = int'($urandom_range(0, 255));
      do_op(w, e, 1'b0);
    end

    // start held high: acceptances every ENV_W+2 cycles
    begin
      int q[$];
      int since;
      int n_acc;
      int n_rdy;
      bit rerand;
      int cw;
      int ce;
      since  = -1;
      n_acc  = 0;
      n_rdy  = 0;
      rerand = 1'b1;
      cw     = 0;
      ce     = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        @(negedge clk_i);
        if (since >= 0) since++;
        if (ready_o) begin
          int exp_p;
          n_rdy++;
          exp_p = (q.size() > 0) ? q.pop_front() : 99999;
          check($sformatf("hold_product cyc=%0d", cyc), prod_int(), exp_p);
          exp_last = exp_p;
          if (since >= 0) check($sformatf("hold_interval cyc=%0d", cyc), since, 10);
          since = 0;
        end else begin
          check($sformatf("hold_stable cyc=%0d", cyc), prod_int(), exp_last);
        end
        start_i = (cyc < 40);
        if (rerand) begin
          cw = int'($urandom_range(0, 4095)) - 2048;
          ce = int'($urandom_range(0, 255));
          drive_ops(cw, ce);
          rerand = 1'b0;
        end
        if (start_i && !busy_o) begin
          q.push_back(ref_mult(cw, ce));
          n_acc++;
          rerand = 1'b1;
        end
      end
      start_i = 1'b0;
      check("hold_accepts", n_acc, 4);
      check("hold_ready_count", n_rdy, n_acc);
      check("hold_queue_empty", q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
